// File: rtl/code_lock_core_if.sv
// Button/status bundle between the code-lock core and its keypad/LED/display side.
interface code_lock_core_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] button;
    logic             lock_req;
    logic             unlocked;
    logic             lockout;
    logic             busy;
    logic [3:0]       entered;
    logic [3:0]       fail_cnt;
    logic             ok_pulse;
    logic             err_pulse;

    modport master (
        output button, lock_req,
        input  unlocked, lockout, busy, entered, fail_cnt, ok_pulse, err_pulse
    );

    modport slave (
        input  button, lock_req,
        output unlocked, lockout, busy, entered, fail_cnt, ok_pulse, err_pulse
    );
endinterface

// File: rtl/code_lock_core.sv
// Parametrised code lock: per-button sync/debounce/press detect feeding a code-entry FSM
// with fail counting, lockout, entry timeout and auto-relock.
module code_lock_core #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [CODE_LEN*((N_BTN > 2) ? $clog2(N_BTN) : 1)-1:0] CODE = 8'h1E,
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned ENTRY_TIMEOUT  = 4096,
    parameter int unsigned UNLOCK_CYCLES  = 2048
) (
    input  logic             clk,
    input  logic             rstn,
    code_lock_core_if.slave  bus
);
    localparam int unsigned BW   = (N_BTN > 2) ? $clog2(N_BTN) : 1;
    localparam int unsigned CW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TMAX_A = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > UNLOCK_CYCLES) ? TMAX_A : UNLOCK_CYCLES;
    localparam int unsigned TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_UNLOCKED, S_LOCKOUT} state_t;

    logic [N_BTN-1:0] sync1, sync2, deb, deb_d, press;
    logic [CW-1:0]    cnt [N_BTN];

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      entered_q, fail_q;
    logic            mismatch_q, unlocked_q, lockout_q, busy_q, ok_q, err_q;

    logic            any_press_c, multi_c, bad_digit_c, attempt_bad_c;
    logic [BW-1:0]   digit_c, exp_digit_c;
    logic [3:0]      next_cnt_c, next_fail_c;

    // Front end: synchronise, debounce, register the debounced rising edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Digit decode; simultaneous presses count as one guaranteed-wrong digit.
    always_comb begin
        any_press_c = 1'b0;
        multi_c     = 1'b0;
        digit_c     = '0;
        exp_digit_c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (press[i]) begin
                multi_c     = multi_c | any_press_c;
                any_press_c = 1'b1;
                digit_c     = BW'(i);
            end
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            if (entered_q == 4'(i)) exp_digit_c = CODE[i*BW +: BW];
        end
        bad_digit_c   = multi_c || (digit_c != exp_digit_c);
        attempt_bad_c = bad_digit_c || ((state == S_ENTRY) && mismatch_q);
        next_cnt_c    = entered_q + 4'd1;
        next_fail_c   = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            timer      <= '0;
            entered_q  <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (any_press_c) begin
                        timer <= '0;
                        if (next_cnt_c == 4'(CODE_LEN)) begin
                            entered_q  <= '0;
                            mismatch_q <= 1'b0;
                            busy_q     <= 1'b0;
                            if (!attempt_bad_c) begin
                                state      <= S_UNLOCKED;
                                unlocked_q <= 1'b1;
                                fail_q     <= '0;
                                ok_q       <= 1'b1;
                            end else begin
                                fail_q <= next_fail_c;
                                err_q  <= 1'b1;
                                if (next_fail_c == 4'(MAX_FAIL)) begin
                                    state     <= S_LOCKOUT;
                                    lockout_q <= 1'b1;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end else begin
                            state      <= S_ENTRY;
                            busy_q     <= 1'b1;
                            entered_q  <= next_cnt_c;
                            mismatch_q <= attempt_bad_c;
                        end
                    end else if (state == S_ENTRY) begin
                        // Stale entry is dropped silently; the fail count is untouched.
                        if (timer == TW'(ENTRY_TIMEOUT - 1)) begin
                            state      <= S_IDLE;
                            busy_q     <= 1'b0;
                            entered_q  <= '0;
                            mismatch_q <= 1'b0;
                            timer      <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (bus.lock_req || (timer == TW'(UNLOCK_CYCLES - 1))) begin
                        state      <= S_IDLE;
                        unlocked_q <= 1'b0;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                        state     <= S_IDLE;
                        lockout_q <= 1'b0;
                        fail_q    <= '0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.unlocked  = unlocked_q;
    assign bus.lockout   = lockout_q;
    assign bus.busy      = busy_q;
    assign bus.entered   = entered_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.ok_pulse  = ok_q;
    assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_code_lock_core.sv
// Bench for code_lock_core: directed and randomised button traffic against an event-level lock model.
module tb_code_lock_core;
    localparam int M_LOCKED = 0, M_ENTER = 1, M_OPEN = 2, M_LOCK = 3;
    localparam int T_UNLOCK = 48, T_LOCK = 32, T_ENTRY = 64, LAT = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   checks = 0, failures = 0;
    int   ok_seen = 0, err_seen = 0;

    // Reference model state: mode, digits of the current attempt, fail count, event times.
    int m_mode, m_fail, t_last, t_mode, n_ok, n_err;
    int q[$];
    int code_d[4] = '{2, 3, 1, 0};

    code_lock_core_if #(.N_BTN(4)) bus();

    code_lock_core #(
        .N_BTN(4), .CODE_LEN(4), .CODE(8'h1E), .DEB_CYCLES(4), .MAX_FAIL(3),
        .LOCKOUT_CYCLES(32), .ENTRY_TIMEOUT(64), .UNLOCK_CYCLES(48)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.ok_pulse === 1'b1)  ok_seen++;
            if (bus.err_pulse === 1'b1) err_seen++;
            if (bus.ok_pulse === 1'b1 || bus.err_pulse === 1'b1)
                chk("pulse_excl", 32'(bus.ok_pulse & bus.err_pulse), 0);
        end
    end

    task automatic model_reset();
        m_mode = M_LOCKED; m_fail = 0; t_last = 0; t_mode = 0;
        q.delete();
    endtask

    // Apply timed expiries for the state as it stands after clock edge `now`.
    task automatic model_sync(input int now);
        if (m_mode == M_ENTER && now - t_last >= T_ENTRY) begin
            m_mode = M_LOCKED; q.delete();
        end
        if (m_mode == M_OPEN && now - t_mode >= T_UNLOCK) m_mode = M_LOCKED;
        if (m_mode == M_LOCK && now - t_mode >= T_LOCK) begin
            m_mode = M_LOCKED; m_fail = 0;
        end
    endtask

    task automatic model_press(input int now, input int digit, output bit eok, output bit eerr);
        bit match;
        model_sync(now - 1);
        eok = 0; eerr = 0;
        if (m_mode == M_LOCKED || m_mode == M_ENTER) begin
            q.push_back(digit);
            t_last = now;
            m_mode = M_ENTER;
            if (q.size() == 4) begin
                match = 1;
                for (int i = 0; i < 4; i++) if (q[i] != code_d[i]) match = 0;
                q.delete();
                if (match) begin
                    m_mode = M_OPEN; t_mode = now; m_fail = 0; eok = 1; n_ok++;
                end else begin
                    m_fail = (m_fail < 15) ? m_fail + 1 : 15;
                    eerr = 1; n_err++;
                    if (m_fail == 3) begin m_mode = M_LOCK; t_mode = now; end
                    else m_mode = M_LOCKED;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        model_sync(cyc);
        chk({tag, "_unlocked"}, 32'(bus.unlocked), 32'(m_mode == M_OPEN));
        chk({tag, "_lockout"},  32'(bus.lockout),  32'(m_mode == M_LOCK));
        chk({tag, "_busy"},     32'(bus.busy),     32'(m_mode == M_ENTER));
        chk({tag, "_entered"},  32'(bus.entered),  (m_mode == M_ENTER) ? 32'(q.size()) : 0);
        chk({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(m_fail));
    endtask

    // Press `mask` after `bounces` short glitches; check nothing moves early and the digit lands on time.
    task automatic press(input logic [3:0] mask, input int hold, input int gap, input int bounces);
        int dig;
        bit eok, eerr;
        dig = -1;
        if ($countones(mask) == 1) for (int i = 0; i < 4; i++) if (mask[i]) dig = i;
        for (int b = 0; b < bounces; b++) begin
            @(negedge clk); bus.button = mask;
            repeat (3) @(negedge clk); bus.button = 4'b0;
            repeat (2) @(negedge clk);
        end
        @(negedge clk); bus.button = mask;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check_all("pre_press");
        @(posedge clk);
        @(negedge clk);
        model_press(cyc, dig, eok, eerr);
        check_all("press");
        chk("ok_pulse",  32'(bus.ok_pulse),  32'(eok));
        chk("err_pulse", 32'(bus.err_pulse), 32'(eerr));
        @(negedge clk);
        chk("ok_pulse_len",  32'(bus.ok_pulse),  0);
        chk("err_pulse_len", 32'(bus.err_pulse), 0);
        repeat (hold - 9) @(negedge clk);
        bus.button = 4'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_lock_req();
        int x;
        @(negedge clk); bus.lock_req = 1'b1;
        @(negedge clk); bus.lock_req = 1'b0;
        x = cyc;
        model_sync(x - 1);
        if (m_mode == M_OPEN) m_mode = M_LOCKED;
        check_all("lock_req");
    endtask

    initial begin
        int tsave, r, hold, gap;
        logic [3:0] mask;
        int wrong[4] = '{2, 3, 1, 1};
        bus.button = 4'b0; bus.lock_req = 1'b0;
        n_ok = 0; n_err = 0;
        model_reset();
        #1 rstn = 1'b0;
        #1 check_all("reset");
        chk("reset_ok",  32'(bus.ok_pulse),  0);
        chk("reset_err", 32'(bus.err_pulse), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Correct code, then auto-relock after exactly T_UNLOCK cycles.
        for (int i = 0; i < 4; i++) press(4'(1 << code_d[i]), 10, 10, 0);
        tsave = t_mode;
        for (int n = 0; n < 200 && bus.unlocked === 1'b1; n++) @(negedge clk);
        chk("unlock_len", 32'(cyc - tsave), T_UNLOCK);
        check_all("relocked");

        // Three wrong attempts lead to a timed lockout.
        for (int a = 0; a < 3; a++)
            for (int i = 0; i < 4; i++) press(4'(1 << wrong[i]), 10, 10, 0);
        tsave = t_mode;
        for (int n = 0; n < 200 && bus.lockout === 1'b1; n++) @(negedge clk);
        chk("lockout_len", 32'(cyc - tsave), T_LOCK);
        check_all("after_lockout");

        // Bounced press yields one digit, then an idle entry times out.
        press(4'b0100, 10, 10, 2);
        press(4'b1000, 10, 10, 0);
        tsave = t_last;
        r = err_seen;
        for (int n = 0; n < 200 && bus.busy === 1'b1; n++) @(negedge clk);
        chk("timeout_len", 32'(cyc - tsave), T_ENTRY);
        check_all("timed_out");
        chk("timeout_no_err", 32'(err_seen), 32'(r));

        // Simultaneous press counts once and spoils the attempt; presses in lockout are ignored.
        press(4'b0011, 10, 10, 0);
        press(4'b1000, 10, 10, 0);
        press(4'b0010, 10, 10, 0);
        press(4'b0001, 10, 10, 0);
        for (int a = 0; a < 2; a++)
            for (int i = 0; i < 4; i++) press(4'(1 << wrong[i]), 10, 10, 0);
        press(4'b0100, 10, 10, 0);
        for (int n = 0; n < 200 && bus.lockout === 1'b1; n++) @(negedge clk);
        check_all("lockout_done");

        // Manual relock.
        for (int i = 0; i < 4; i++) press(4'(1 << code_d[i]), 10, 10, 0);
        pulse_lock_req();

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
                else if ($urandom_range(0, 1) == 0 && q.size() < 4) mask = 4'(1 << code_d[q.size()]);
                else mask = 4'(1 << $urandom_range(0, 3));
                hold = $urandom_range(9, 14);
                gap  = ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(6, 30);
                press(mask, hold, gap, 0);
            end else if (r == 7) begin
                pulse_lock_req();
            end else begin
                repeat ($urandom_range(1, 90)) @(negedge clk);
                check_all("idle");
            end
        end

        // Reset in the middle of an entry clears everything asynchronously.
        repeat (70) @(negedge clk);
        press(4'b0100, 10, 10, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        chk("mid_reset_ok",  32'(bus.ok_pulse),  0);
        chk("mid_reset_err", 32'(bus.err_pulse), 0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);

        chk("ok_total",  32'(ok_seen),  32'(n_ok));
        chk("err_total", 32'(err_seen), 32'(n_err));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
